// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the four-stage MIPS pipeline-register bank.
// Optional statistics counters are built only when PIPE_STATS_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_ex,
    input  logic [4:0]       rt_ex,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             dREN_mem,
    input  logic             dWEN_mem,
    input  logic             redirect_mem,
    input  logic             halt_wb,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_bub_cnt;
    logic [1:0] w_next_bub;
    logic       w_mem_busy;
    logic       w_load_use;

    assign w_mem_busy = (dREN_mem | dWEN_mem) & ~dhit;
    assign w_load_use = dREN_ex & (rt_ex != 5'd0) & ((rt_ex == rs_id) | (rt_ex == rt_id));

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state   <= RUN;
            r_bub_cnt <= 2'd0;
        end else begin
            r_state   <= w_next_state;
            r_bub_cnt <= w_next_bub;
        end
    end

    // Priority: halt > memory freeze > redirect > load-use bubble > fetch miss > normal.
    always_comb begin
        w_next_state = r_state;
        w_next_bub   = r_bub_cnt;
        en_ifid      = 1'b0;
        en_idex      = 1'b0;
        en_exmem     = 1'b0;
        en_memwb     = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        flush_exmem  = 1'b0;
        pc_en        = 1'b0;
        halted       = 1'b0;
        if (nRST) begin
            case (r_state)
                HALT: halted = 1'b1;
                default: begin
                    if (halt_wb) begin
                        w_next_state = HALT;
                    end else if (!w_mem_busy) begin
                        if (redirect_mem) begin
                            {en_ifid, en_idex, en_exmem, en_memwb} = 4'hF;
                            {flush_ifid, flush_idex, flush_exmem}  = 3'b111;
                            pc_en        = 1'b1;
                            w_next_state = RUN;
                            w_next_bub   = 2'd0;
                        end else if ((r_state == LDSTALL) || w_load_use) begin
                            en_idex    = 1'b1;
                            flush_idex = 1'b1;
                            en_exmem   = 1'b1;
                            en_memwb   = 1'b1;
                            if (r_state == LDSTALL) begin
                                w_next_bub = r_bub_cnt - 2'd1;
                                if (r_bub_cnt <= 2'd1) begin
                                    w_next_state = RUN;
                                    w_next_bub   = 2'd0;
                                end
                            end else if (LOAD_USE_BUBBLES > 1) begin
                                w_next_state = LDSTALL;
                                w_next_bub   = 2'(LOAD_USE_BUBBLES - 1);
                            end
                        end else if (!ihit) begin
                            {en_ifid, en_idex, en_exmem, en_memwb} = 4'hF;
                            flush_ifid = 1'b1;
                        end else begin
                            {en_ifid, en_idex, en_exmem, en_memwb} = 4'hF;
                            pc_en = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    // flush_exmem is asserted only when a redirect is acted on.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_en && (r_state != HALT) && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (flush_exmem && (r_flush_count != '1))
                r_flush_count <= r_flush_count + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
